// File: rtl/ccff_chain_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_pkg
// Brief    : Shared FSM states and bit-serial CRC-16-CCITT helper for the
//            configuration-chain loader.
// Revision : 1.0
// ============================================================================
package ccff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_READBACK = 3'd3,
        ST_DONE     = 3'd4
    } ccff_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader_if
// Brief    : Valid/ready bitstream word stream feeding the chain loader.
// Revision : 1.0
// ============================================================================
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface
`default_nettype wire

// File: rtl/ccff_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module   : ccff_crc16_serial
// Brief    : One-bit-per-cycle CRC-16-CCITT accumulator with synchronous clear.
// Revision : 1.0
// ============================================================================
module ccff_crc16_serial
    import ccff_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire         i_clear,
    input  wire         i_en,
    input  wire         i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_bit(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Brief    : Serializes bitstream words into a configuration chain head and
//            optionally reads the chain back through a recirculating CRC check.
// Revision : 1.0
// ============================================================================
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  wire              prog_clk,
    input  wire              pReset,
    input  wire              start,
    input  wire              verify_en,
    ccff_chain_loader_if.slave word_if,
    output logic             ccff_head,
    output logic             ccff_clk_en,
    input  wire              ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [2:0] c_ST_IDLE     = ST_IDLE;
    localparam logic [2:0] c_ST_FETCH    = ST_FETCH;
    localparam logic [2:0] c_ST_SHIFT    = ST_SHIFT;
    localparam logic [2:0] c_ST_READBACK = ST_READBACK;
    localparam logic [2:0] c_ST_DONE     = ST_DONE;

    localparam int                 c_IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]   c_LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]         r_state;
    logic [WORD_W-1:0]  r_word;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_verify;

    logic        w_start_ok;
    logic        w_load_en;
    logic        w_rb_en;
    logic [15:0] w_load_crc;
    logic [15:0] w_rb_crc;

    assign w_start_ok = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_load_en  = (r_state == c_ST_SHIFT);
    assign w_rb_en    = (r_state == c_ST_READBACK);
    assign busy       = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);

    ccff_crc16_serial u_load_crc (
        .clk     (prog_clk),
        .rst     (pReset),
        .i_clear (w_start_ok),
        .i_en    (w_load_en),
        .i_bit   (r_word[0]),
        .o_crc   (w_load_crc)
    );

    ccff_crc16_serial u_rb_crc (
        .clk     (prog_clk),
        .rst     (pReset),
        .i_clear (w_start_ok),
        .i_en    (w_rb_en),
        .i_bit   (ccff_tail),
        .o_crc   (w_rb_crc)
    );

    // Readback recirculates the tail into the head so the chain ends up unchanged.
    always_comb begin
        ccff_head          = 1'b0;
        ccff_clk_en        = 1'b0;
        word_if.word_ready = 1'b0;
        case (r_state)
            c_ST_FETCH:    word_if.word_ready = 1'b1;
            c_ST_SHIFT: begin
                ccff_head   = r_word[0];
                ccff_clk_en = 1'b1;
            end
            c_ST_READBACK: begin
                ccff_head   = ccff_tail;
                ccff_clk_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state   <= c_ST_IDLE;
            r_word    <= '0;
            r_idx     <= '0;
            r_verify  <= 1'b0;
            bit_count <= '0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state   <= c_ST_FETCH;
                        r_verify  <= verify_en;
                        bit_count <= '0;
                        done      <= 1'b0;
                        crc_ok    <= 1'b0;
                    end
                end
                c_ST_FETCH: begin
                    if (word_if.word_valid) begin
                        r_word  <= word_if.word_data;
                        r_idx   <= '0;
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    r_word    <= r_word >> 1;
                    r_idx     <= r_idx + 1'b1;
                    bit_count <= bit_count + 1'b1;
                    // Chain-full wins over word-exhausted: leftover word bits are dropped.
                    if (bit_count == c_LAST_BIT) begin
                        if (r_verify) begin
                            r_state   <= c_ST_READBACK;
                            bit_count <= '0;
                        end else begin
                            r_state <= c_ST_DONE;
                            done    <= 1'b1;
                            crc_ok  <= 1'b1;
                        end
                    end else if (r_idx == c_IDX_LAST) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_READBACK: begin
                    bit_count <= bit_count + 1'b1;
                    if (bit_count == c_LAST_BIT) begin
                        r_state <= c_ST_DONE;
                        done    <= 1'b1;
                        // Fold in the final tail bit, which the accumulator only sees next edge.
                        crc_ok  <= (crc16_bit(w_rb_crc, ccff_tail) == w_load_crc);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Brief    : Self-checking bench: behavioural 36-flop chain plus a bit-stream
//            and CRC reference model driven by directed and random loads.
// Revision : 1.0
// ============================================================================
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 36;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 16;
    localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic             prog_clk  = 1'b0;
    logic             pReset    = 1'b0;
    logic             start     = 1'b0;
    logic             verify_en = 1'b0;
    logic             ccff_head, ccff_clk_en, ccff_tail, busy, done, crc_ok;
    logic [CNT_W-1:0] bit_count;

    logic [CHAIN_LEN-1:0] chain   = '0;
    int                   en_cnt  = 0;
    int                   cyc     = 0;
    int                   flip_at = -1;
    int                   n_cmp   = 0;
    int                   n_fail  = 0;
    logic [WORD_W-1:0]    words [N_WORDS];

    ccff_chain_loader_if #(.WORD_W(WORD_W)) word_if ();

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .verify_en   (verify_en),
        .word_if     (word_if),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .crc_ok      (crc_ok),
        .bit_count   (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: head enters at the top, tail is bit 0.
    assign ccff_tail = chain[0];
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_clk_en) begin
            chain  <= {ccff_head, chain[CHAIN_LEN-1:1]} ^
                      ((en_cnt == flip_at) ? (CHAIN_LEN'(1) << 17) : '0);
            en_cnt <= en_cnt + 1;
        end
    end

    function automatic logic [CHAIN_LEN-1:0] model_chain();
        logic [CHAIN_LEN-1:0] c;
        for (int i = 0; i < CHAIN_LEN; i++) c[i] = words[i / WORD_W][i % WORD_W];
        return c;
    endfunction

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        b;
        c = 16'hFFFF;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            b = words[i / WORD_W][i % WORD_W];
            if (c[15] ^ b) c = {c[14:0], 1'b0} ^ 16'h1021;
            else           c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic v);
        verify_en = v;
        start     = 1'b1;
        @(negedge prog_clk);
        start     = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        int t;
        t = 0;
        word_if.word_data  = w;
        word_if.word_valid = 1'b1;
        while (!word_if.word_ready && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        chk("ready_timeout", 64'(t < 200), 64'(1));
        @(negedge prog_clk);
        word_if.word_valid = 1'b0;
    endtask

    task automatic run_load(input logic v, input logic exp_ok, input int stall_idx,
                            input int stall_len, input logic poke_start, input logic chk_chain);
        int base, c0, t;
        base = en_cnt;
        pulse_start(v);
        c0 = cyc;
        chk("start_bitcnt", 64'(bit_count), 64'(0));
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_done", 64'(done), 64'(0));
        for (int w = 0; w < N_WORDS; w++) begin
            if (w == stall_idx) begin
                t = 0;
                while (!word_if.word_ready && t < 100) begin
                    @(negedge prog_clk);
                    t++;
                end
                for (int s = 0; s < stall_len; s++) begin
                    chk("stall_clk_en", 64'(ccff_clk_en), 64'(0));
                    chk("stall_ready", 64'(word_if.word_ready), 64'(1));
                    chk("stall_bitcnt", 64'(bit_count), 64'(w * WORD_W));
                    if (poke_start && s == stall_len / 2) begin
                        verify_en = 1'b1;
                        start     = 1'b1;
                    end
                    @(negedge prog_clk);
                    start     = 1'b0;
                    verify_en = 1'b0;
                end
            end
            send_word(words[w]);
        end
        t = 0;
        while (!done && t < 1000) begin
            @(negedge prog_clk);
            t++;
        end
        chk("done_timeout", 64'(done), 64'(1));
        if (stall_idx < 0)
            chk("latency", 64'(cyc - c0), 64'(CHAIN_LEN + N_WORDS + (v ? CHAIN_LEN : 0)));
        chk("crc_ok", 64'(crc_ok), 64'(exp_ok));
        chk("end_busy", 64'(busy), 64'(0));
        chk("end_bitcnt", 64'(bit_count), 64'(CHAIN_LEN));
        chk("clk_en_cycles", 64'(en_cnt - base), 64'(v ? 2 * CHAIN_LEN : CHAIN_LEN));
        chk("load_crc", 64'(dut.w_load_crc), 64'(model_crc()));
        if (chk_chain) begin
            chk("chain", 64'(chain), 64'(model_chain()));
            if (v) chk("rb_crc", 64'(dut.w_rb_crc), 64'(model_crc()));
        end
    endtask

    task automatic set_fixed_words();
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
    endtask

    initial begin
        int t, en_hold;
        word_if.word_data  = '0;
        word_if.word_valid = 1'b0;
        #2 pReset = 1'b1;
        @(negedge prog_clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_crc_ok", 64'(crc_ok), 64'(0));
        chk("rst_clk_en", 64'(ccff_clk_en), 64'(0));
        chk("rst_head", 64'(ccff_head), 64'(0));
        chk("rst_ready", 64'(word_if.word_ready), 64'(0));
        chk("rst_bitcnt", 64'(bit_count), 64'(0));
        chk("rst_load_crc", 64'(dut.w_load_crc), 64'(16'hFFFF));
        chk("rst_rb_crc", 64'(dut.w_rb_crc), 64'(16'hFFFF));
        pReset = 1'b0;
        @(negedge prog_clk);

        // Plain load, then with readback verification.
        set_fixed_words();
        run_load(1'b0, 1'b1, -1, 0, 1'b0, 1'b1);
        run_load(1'b1, 1'b1, -1, 0, 1'b0, 1'b1);

        // Corrupt flop 17 on the first readback shift.
        flip_at = en_cnt + CHAIN_LEN;
        run_load(1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        flip_at = -1;

        // Stall before word 3 with a stray start pulse while busy.
        run_load(1'b0, 1'b1, 3, 10, 1'b1, 1'b1);

        // word_valid held in DONE must not be consumed or restart anything.
        word_if.word_data  = 8'h5A;
        word_if.word_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge prog_clk);
            chk("done_ready", 64'(word_if.word_ready), 64'(0));
            chk("done_hold", 64'(done), 64'(1));
            chk("done_bitcnt", 64'(bit_count), 64'(CHAIN_LEN));
        end
        word_if.word_valid = 1'b0;

        // Reset in the middle of the load.
        pulse_start(1'b0);
        send_word(words[0]);
        send_word(words[1]);
        send_word(words[2]);
        t = 0;
        while (bit_count != CNT_W'(20) && t < 50) begin
            @(negedge prog_clk);
            t++;
        end
        chk("bit20_reached", 64'(bit_count), 64'(20));
        pReset = 1'b1;
        #1;
        chk("mid_rst_clk_en", 64'(ccff_clk_en), 64'(0));
        chk("mid_rst_head", 64'(ccff_head), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_crc_ok", 64'(crc_ok), 64'(0));
        chk("mid_rst_bitcnt", 64'(bit_count), 64'(0));
        chk("mid_rst_ready", 64'(word_if.word_ready), 64'(0));
        en_hold = en_cnt;
        repeat (5) @(negedge prog_clk);
        chk("mid_rst_no_shift", 64'(en_cnt), 64'(en_hold));
        pReset = 1'b0;
        @(negedge prog_clk);
        run_load(1'b0, 1'b1, -1, 0, 1'b0, 1'b1);

        // Random payloads, random verify and stall placement.
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < N_WORDS; w++) words[w] = WORD_W'($urandom);
            run_load(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 5), $urandom_range(1, 6),
                     1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
